rr_dff_bank_arbiter: RTL and testbench
======================================

# rr_dff_bank_arbiter

Round-robin arbiter that shares one W-bit D-flip-flop result register among N requesters. Each requester presents data and a request. The arbiter picks one winner fairly, loads its data into the shared register, and returns a one-cycle grant. It sits in front of the positive-edge register primitives and serialises writes to them from multiple sources.

## Interface
Parameters:
- N, 4, number of requesters (2..8)
- W, 8, data width per requester and of the shared register
- SW, $clog2(N), width of the source index

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-low
- req  input  N  request vector; bit i is held high by requester i until it sees gnt[i]
- data  input  N*W  packed data; requester i occupies bits [i*W +: W]
- lock  input  N  lock request; only present when ARB_LOCK_EN is defined
- gnt  output  N  one-hot grant, registered
- q  output  W  shared register contents
- q_valid  output  1  pulses high for one cycle on the cycle q was loaded
- q_src  output  SW  index of the requester whose data is in q
- busy  output  1  high whenever the FSM is not in IDLE

## Operation
- Reset (rst=0), asynchronous:
  - gnt=0, q=0, q_valid=0, q_src=0, busy=0
  - priority pointer ptr=0
  - FSM to IDLE
- FSM states: IDLE, GRANT, LOCKED (LOCKED only with ARB_LOCK_EN).
- IDLE:
  - If req≠0, the winner w is the first set bit of req scanning upward from ptr and wrapping N-1→0.
  - At the edge: gnt[w]←1, q←data[w], q_src←w, q_valid←1, ptr←(w+1) mod N, go to GRANT.
  - If req=0, stay in IDLE with all outputs pulsed low; q and q_src hold.
- GRANT, which lasts exactly one cycle:
  - Normally: next edge clears gnt and q_valid and returns to IDLE. This is a mandatory one-cycle gap so the requester can drop req.
  - With ARB_LOCK_EN and lock[w]=1 sampled in GRANT: go to LOCKED instead.
- LOCKED:
  - gnt[w] stays high.
  - Each edge reloads q←data[w] with q_valid=1.
  - When lock[w]=0 is sampled: gnt and q_valid clear, go to IDLE.
  - ptr is unchanged while locked.
- Fairness: a requester that holds req continuously is granted within N grant opportunities.
- Boundaries:
  - ptr wraps modulo N; for non-power-of-two N, (N-1)+1→0.
  - req bits that drop before being granted are simply ignored; no grant is issued.
  - req bits above N do not exist; lock[i] for i≠w is ignored.
  - Reset asserted mid-GRANT or mid-LOCKED clears everything immediately, with no partial write.
  - If req[w] is still high in the cycle after GRANT, it competes normally at its new lowest priority.

## Timing
- Request-to-grant latency: 1 cycle. req is sampled at edge k; gnt, q and q_valid are visible after edge k.
- Grant throughput: at most one grant per 2 cycles (IDLE→GRANT→IDLE).
- q is stable between loads. q_valid is coincident with gnt.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- ARB_LOCK_EN defined:
  - The lock port exists and the LOCKED state is built.
  - A locked requester streams one W-bit word per cycle into q.
- ARB_LOCK_EN undefined:
  - No lock port and no LOCKED state.
  - Every grant is exactly one cycle long.

## Structure
- Shared package rr_arb_pkg holds:
  - the FSM state enum (IDLE, GRANT, LOCKED)
  - the default N and W constants
- The natural sub-module is rr_pick: a combinational round-robin priority picker taking (req, ptr) and returning the winner index plus an any-request flag.
- The FSM, shared register and pointer live in the top level.

## Test plan
- Reset: hold rst=0 with req=4'b1111 → gnt=0, q=0, q_valid=0, busy=0 throughout.
- Single request: req=4'b0100, data[2]=8'hA5 → after 1 edge gnt=4'b0100, q=8'hA5, q_src=2; next cycle gnt=0, busy=0.
- Fairness: req=4'b1111 held → grant order 0,1,2,3,0 on cycles 1,3,5,7,9.
- Wrap: ptr=3 after a grant to requester 2, then req=4'b1001 → requester 3 wins; then requester 0 wins.
- Reset mid-grant: drop rst in GRANT → all outputs 0 immediately; after release with req=4'b0010, requester 1 wins.
- Lock (ARB_LOCK_EN): req[1]=lock[1]=1 with data[1] incrementing 1,2,3 → gnt[1] stays high and q=1,2,3 on consecutive cycles; lock drop → IDLE; ptr=2.

Source files
------------

// File: rtl/rr_dff_bank_arbiter_pkg.sv
// Shared types and defaults for the round-robin DFF bank arbiter.
// The LOCKED state exists only when ARB_LOCK_EN is defined.
package rr_arb_pkg;

  localparam int unsigned ARB_N_DEF = 4;
  localparam int unsigned ARB_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    GRANT
`ifdef ARB_LOCK_EN
    , LOCKED
`endif
  } arb_state_e;

endpackage

// File: rtl/rr_dff_bank_arbiter_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping from N-1 back to 0.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] win,
  output logic          any
);

  int unsigned idx;

  // Scan upward from ptr and keep the first requester found.
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!any && req[idx[SW-1:0]]) begin
        any = 1'b1;
        win = idx[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_dff_bank_arbiter.sv
// Round-robin arbiter sharing one W-bit result register among N requesters.
// Optional feature macro: ARB_LOCK_EN (adds lock port and LOCKED streaming).
module rr_dff_bank_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned N  = ARB_N_DEF,
  parameter int unsigned W  = ARB_W_DEF,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data,
`ifdef ARB_LOCK_EN
  input  logic [N-1:0]   lock,
`endif
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   q,
  output logic           q_valid,
  output logic [SW-1:0]  q_src,
  output logic           busy
);

  arb_state_e    state, state_d;
  logic [SW-1:0] ptr, ptr_d;
  logic [SW-1:0] win;
  logic          any;
  logic [N-1:0]  gnt_d;
  logic [W-1:0]  q_d;
  logic          qv_d;
  logic [SW-1:0] src_d;
  logic [W-1:0]  data_a [N];

  rr_pick #(.N(N), .SW(SW)) u_pick (
    .req (req),
    .ptr (ptr),
    .win (win),
    .any (any)
  );

  // Unpack the flat data bus into per-requester words.
  always_comb begin
    for (int unsigned k = 0; k < N; k++) begin
      data_a[k] = data[k*W +: W];
    end
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      q_src   <= '0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      gnt     <= gnt_d;
      q       <= q_d;
      q_valid <= qv_d;
      q_src   <= src_d;
    end
  end

  // Next-state: one-cycle GRANT, optionally extended into LOCKED.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (any) state_d = GRANT;
      GRANT: begin
        state_d = IDLE;
`ifdef ARB_LOCK_EN
        if (lock[q_src]) state_d = LOCKED;
      end
      LOCKED: begin
        if (!lock[q_src]) state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and the priority pointer.
  always_comb begin
    gnt_d = '0;
    q_d   = q;
    qv_d  = 1'b0;
    src_d = q_src;
    ptr_d = ptr;
    case (state)
      IDLE: begin
        if (any) begin
          gnt_d[win] = 1'b1;
          q_d        = data_a[win];
          qv_d       = 1'b1;
          src_d      = win;
          ptr_d      = (win == SW'(N-1)) ? '0 : win + SW'(1);
        end
      end
`ifdef ARB_LOCK_EN
      GRANT, LOCKED: begin
        if (lock[q_src]) begin
          gnt_d[q_src] = 1'b1;
          q_d          = data_a[q_src];
          qv_d         = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_rr_dff_bank_arbiter.sv
// Directed testbench for rr_dff_bank_arbiter (default build, N=4, W=8).
module tb_rr_dff_bank_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        q_valid;
  logic [1:0]  q_src;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  rr_dff_bank_arbiter #(.N(4), .W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .data    (data),
    .gnt     (gnt),
    .q       (q),
    .q_valid (q_valid),
    .q_src   (q_src),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #20000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_gnt, input logic [7:0] e_q,
                         input logic e_qv, input logic [1:0] e_src, input logic e_busy);
    chk({tag, "_gnt"},  32'(gnt),     32'(e_gnt));
    chk({tag, "_q"},    32'(q),       32'(e_q));
    chk({tag, "_qv"},   32'(q_valid), 32'(e_qv));
    chk({tag, "_src"},  32'(q_src),   32'(e_src));
    chk({tag, "_busy"}, 32'(busy),    32'(e_busy));
  endtask

  initial begin
    rst  = 1'b0;
    req  = 4'b1111;
    data = {8'h13, 8'h12, 8'h11, 8'h10};

    // Reset held with all requests active: nothing may be granted.
    repeat (3) begin
      @(negedge clk);
      chk_all("reset", 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0);
    end

    // Release reset, then all four request continuously.
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    req = 4'b1111;

    @(negedge clk); chk_all("fair0", 4'b0001, 8'h10, 1'b1, 2'd0, 1'b1);
    @(negedge clk); chk_all("gap0",  4'b0000, 8'h10, 1'b0, 2'd0, 1'b0);
    @(negedge clk); chk_all("fair1", 4'b0010, 8'h11, 1'b1, 2'd1, 1'b1);
    @(negedge clk); chk_all("gap1",  4'b0000, 8'h11, 1'b0, 2'd1, 1'b0);
    @(negedge clk); chk_all("fair2", 4'b0100, 8'h12, 1'b1, 2'd2, 1'b1);
    @(negedge clk); chk_all("gap2",  4'b0000, 8'h12, 1'b0, 2'd2, 1'b0);
    @(negedge clk); chk_all("fair3", 4'b1000, 8'h13, 1'b1, 2'd3, 1'b1);
    @(negedge clk); chk_all("gap3",  4'b0000, 8'h13, 1'b0, 2'd3, 1'b0);
    @(negedge clk); chk_all("fair4", 4'b0001, 8'h10, 1'b1, 2'd0, 1'b1);
    @(negedge clk); chk_all("gap4",  4'b0000, 8'h10, 1'b0, 2'd0, 1'b0);
    req = 4'b0000;

    // No requests: idle, q and q_src hold (ptr is now 1).
    @(negedge clk); chk_all("idle", 4'b0000, 8'h10, 1'b0, 2'd0, 1'b0);

    // Single request from requester 2.
    data = {8'h13, 8'hA5, 8'h11, 8'h10};
    req  = 4'b0100;
    @(negedge clk); chk_all("single", 4'b0100, 8'hA5, 1'b1, 2'd2, 1'b1);
    req = 4'b0000;
    @(negedge clk); chk_all("single_gap", 4'b0000, 8'hA5, 1'b0, 2'd2, 1'b0);

    // Wrap: ptr=3, requesters 3 and 0 compete; 3 first, then 0.
    req = 4'b1001;
    @(negedge clk); chk_all("wrap3", 4'b1000, 8'h13, 1'b1, 2'd3, 1'b1);
    req = 4'b0001;
    @(negedge clk); chk_all("wrap_gap", 4'b0000, 8'h13, 1'b0, 2'd3, 1'b0);
    @(negedge clk); chk_all("wrap0", 4'b0001, 8'h10, 1'b1, 2'd0, 1'b1);
    req = 4'b0000;
    @(negedge clk); chk_all("wrap0_gap", 4'b0000, 8'h10, 1'b0, 2'd0, 1'b0);

    // Request that drops before any edge sees it is ignored.
    req = 4'b0100;
    #2 req = 4'b0000;
    @(negedge clk); chk_all("dropped", 4'b0000, 8'h10, 1'b0, 2'd0, 1'b0);

    // Reset asserted mid-GRANT clears all outputs at once (ptr is 1).
    req = 4'b0010;
    @(negedge clk); chk_all("pre_rst", 4'b0010, 8'h11, 1'b1, 2'd1, 1'b1);
    rst = 1'b0;
    #1 chk_all("mid_rst", 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0);

    // After release ptr restarts at 0: of requesters 1 and 2, 1 wins.
    req = 4'b0110;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); chk_all("post_rst", 4'b0010, 8'h11, 1'b1, 2'd1, 1'b1);
    req = 4'b0000;
    @(negedge clk); chk_all("post_gap", 4'b0000, 8'h11, 1'b0, 2'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
